// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared FSM type and sizing helper for the restoring divider
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } divider_fsm_t;

    // Width of the step counter; it only needs to hold DATA_WIDTH-1.
    function automatic int counter_width(input int data_width);
        return $clog2(data_width);
    endfunction

endpackage

// File: rtl/restoring_divider_step.sv
// rtl/restoring_divider_step.sv - one shift/trial-subtract/restore step of the restoring divider
module restoring_divider_step
    import divider_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] rem_in,
    input  logic                  bit_in,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] rem_out,
    output logic                  quot_bit
);

    // Shifted partial remainder is one bit wider than the operands, so the
    // sign of the trial subtraction comes from a full-width compare.
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH-1:0] trial;
    logic                  negative;

    assign shifted  = {rem_in, bit_in};
    assign negative = (shifted < {1'b0, divisor});

    // When the trial is non-negative it is smaller than the divisor, so the
    // low DATA_WIDTH bits of the difference are the exact result.
    assign trial    = shifted[DATA_WIDTH-1:0] - divisor;

    assign quot_bit = ~negative;
    assign rem_out  = negative ? shifted[DATA_WIDTH-1:0] : trial;

endmodule

// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - multicycle restoring divider, one quotient bit per clock (signed option: DIVIDER_SIGNED_EN)
module restoring_divider
    import divider_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    input  logic                  data_valid_i,
    output logic [DATA_WIDTH-1:0] quotient_o,
    output logic [DATA_WIDTH-1:0] remainder_o,
    output logic                  data_valid_o,
    output logic                  divide_by_zero_o,
    output logic                  idle_o
);

    localparam int CW = counter_width(DATA_WIDTH);

    divider_fsm_t          state;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] rem_q;    // partial remainder
    logic [DATA_WIDTH-1:0] dvd_q;    // dividend shifting out, quotient shifting in
    logic [DATA_WIDTH-1:0] dsr_q;    // latched divisor magnitude
    logic                  dbz_q;

    logic [DATA_WIDTH-1:0] dvd_mag;
    logic [DATA_WIDTH-1:0] dsr_mag;
    logic [DATA_WIDTH-1:0] q_fix;
    logic [DATA_WIDTH-1:0] r_fix;
    logic [DATA_WIDTH-1:0] rem_next;
    logic                  q_bit;

    assign idle_o = (state == IDLE);

`ifdef DIVIDER_SIGNED_EN
    logic neg_quot;
    logic neg_rem;

    // The unsigned core runs on magnitudes; MIN stays MIN, which reads as
    // the correct unsigned magnitude 2^(DATA_WIDTH-1).
    assign dvd_mag = dividend_i[DATA_WIDTH-1] ? -dividend_i : dividend_i;
    assign dsr_mag = divisor_i[DATA_WIDTH-1]  ? -divisor_i  : divisor_i;
    assign q_fix   = neg_quot ? -dvd_q : dvd_q;
    assign r_fix   = neg_rem  ? -rem_q : rem_q;

    // Capture result signs on acceptance; divide-by-zero passes raw values through.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
        end else if (state == IDLE && data_valid_i) begin
            if (divisor_i == '0) begin
                neg_quot <= 1'b0;
                neg_rem  <= 1'b0;
            end else begin
                neg_quot <= dividend_i[DATA_WIDTH-1] ^ divisor_i[DATA_WIDTH-1];
                neg_rem  <= dividend_i[DATA_WIDTH-1];
            end
        end
    end
`else
    assign dvd_mag = dividend_i;
    assign dsr_mag = divisor_i;
    assign q_fix   = dvd_q;
    assign r_fix   = rem_q;
`endif

    restoring_divider_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .rem_in   (rem_q),
        .bit_in   (dvd_q[DATA_WIDTH-1]),
        .divisor  (dsr_q),
        .rem_out  (rem_next),
        .quot_bit (q_bit)
    );

    // Control FSM, datapath registers and result registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state            <= IDLE;
            count            <= '0;
            rem_q            <= '0;
            dvd_q            <= '0;
            dsr_q            <= '0;
            dbz_q            <= 1'b0;
            quotient_o       <= '0;
            remainder_o      <= '0;
            data_valid_o     <= 1'b0;
            divide_by_zero_o <= 1'b0;
        end else begin
            data_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_valid_i) begin
                        dsr_q <= dsr_mag;
                        if (divisor_i == '0) begin
                            dvd_q <= '1;
                            rem_q <= dividend_i;
                            dbz_q <= 1'b1;
                            state <= DONE;
                        end else begin
                            dvd_q <= dvd_mag;
                            rem_q <= '0;
                            dbz_q <= 1'b0;
                            count <= CW'(DATA_WIDTH - 1);
                            state <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    rem_q <= rem_next;
                    dvd_q <= {dvd_q[DATA_WIDTH-2:0], q_bit};
                    count <= count - 1'b1;
                    if (count == '0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    quotient_o       <= q_fix;
                    remainder_o      <= r_fix;
                    divide_by_zero_o <= dbz_q;
                    data_valid_o     <= 1'b1;
                    state            <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// tb/tb_restoring_divider.sv - directed self-checking bench for restoring_divider
module tb_restoring_divider;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         start;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         valid;
    logic         dbz;
    logic         idle;

    int checks = 0;
    int errors = 0;

    restoring_divider #(
        .DATA_WIDTH (W)
    ) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .dividend_i       (dividend),
        .divisor_i        (divisor),
        .data_valid_i     (start),
        .quotient_o       (quotient),
        .remainder_o      (remainder),
        .data_valid_o     (valid),
        .divide_by_zero_o (dbz),
        .idle_o           (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one cycle, then count negedges until data_valid_o (bounded).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        #1;
        checks++;
        if (quotient !== 8'd0 || remainder !== 8'd0 || valid !== 1'b0 || dbz !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL reset: q=%0d r=%0d v=%b dbz=%b idle=%b, want 0 0 0 0 1", quotient, remainder, valid, dbz, idle);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        run_op(8'd100, 8'd7, lat);
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL basic_latency: got %0d want 9", lat);
        end
        checks++;
        if (quotient !== 8'd14 || remainder !== 8'd2 || dbz !== 1'b0) begin
            errors++;
            $display("FAIL basic_100_7: q=%0d r=%0d dbz=%b want 14 2 0", quotient, remainder, dbz);
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || quotient !== 8'd14) begin
            errors++;
            $display("FAIL basic_pulse_hold: v=%b q=%0d want 0 14", valid, quotient);
        end
    endtask

    task automatic test_div_zero();
        int lat;
        run_op(8'd5, 8'd0, lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL dbz_latency: got %0d want 1", lat);
        end
        checks++;
        if (quotient !== 8'hFF || remainder !== 8'd5 || dbz !== 1'b1) begin
            errors++;
            $display("FAIL dbz_5_0: q=%0h r=%0d dbz=%b want ff 5 1", quotient, remainder, dbz);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (dbz !== 1'b1 || quotient !== 8'hFF) begin
            errors++;
            $display("FAIL dbz_hold: dbz=%b q=%0h want 1 ff", dbz, quotient);
        end
        run_op(8'd9, 8'd3, lat);
        checks++;
        if (lat !== 9 || quotient !== 8'd3 || remainder !== 8'd0 || dbz !== 1'b0) begin
            errors++;
            $display("FAIL dbz_clear_9_3: lat=%0d q=%0d r=%0d dbz=%b want 9 3 0 0", lat, quotient, remainder, dbz);
        end
    endtask

    task automatic test_boundaries();
        int lat;
        run_op(8'd255, 8'd1, lat);
        checks++;
        if (lat !== 9 || quotient !== 8'd255 || remainder !== 8'd0) begin
            errors++;
            $display("FAIL bound_255_1: lat=%0d q=%0d r=%0d want 9 255 0", lat, quotient, remainder);
        end
        run_op(8'd3, 8'd200, lat);
        checks++;
        if (lat !== 9 || quotient !== 8'd0 || remainder !== 8'd3) begin
            errors++;
            $display("FAIL bound_3_200: lat=%0d q=%0d r=%0d want 9 0 3", lat, quotient, remainder);
        end
        run_op(8'd0, 8'd5, lat);
        checks++;
        if (quotient !== 8'd0 || remainder !== 8'd0 || dbz !== 1'b0) begin
            errors++;
            $display("FAIL bound_0_5: q=%0d r=%0d dbz=%b want 0 0 0", quotient, remainder, dbz);
        end
        run_op(8'd200, 8'd13, lat);
        checks++;
        if (quotient !== 8'd15 || remainder !== 8'd5) begin
            errors++;
            $display("FAIL bound_200_13: q=%0d r=%0d want 15 5", quotient, remainder);
        end
    endtask

    task automatic test_ignore_inflight();
        int lat;
        int busy_bad;
        int extra;
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'd1;
        divisor  = 8'd1;
        busy_bad = 0;
        lat      = 0;
        while (!valid && lat < 30) begin
            if (idle !== 1'b0) busy_bad++;
            if (lat == 3) start = 1'b1;
            if (lat == 4) start = 1'b0;
            @(negedge clk);
            lat++;
        end
        checks++;
        if (busy_bad !== 0) begin
            errors++;
            $display("FAIL inflight_idle: idle high %0d times want 0", busy_bad);
        end
        checks++;
        if (lat !== 9 || quotient !== 8'd14 || remainder !== 8'd2) begin
            errors++;
            $display("FAIL inflight_result: lat=%0d q=%0d r=%0d want 9 14 2", lat, quotient, remainder);
        end
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL inflight_idle_after: idle=%b want 1", idle);
        end
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (valid) extra++;
        end
        checks++;
        if (extra !== 0 || quotient !== 8'd14) begin
            errors++;
            $display("FAIL inflight_no_second: pulses=%0d q=%0d want 0 14", extra, quotient);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int pulses;
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 8'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (quotient !== 8'd0 || remainder !== 8'd0 || valid !== 1'b0 || dbz !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: q=%0d r=%0d v=%b dbz=%b idle=%b want 0 0 0 0 1", quotient, remainder, valid, dbz, idle);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (valid) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_pulse: pulses=%0d want 0", pulses);
        end
        run_op(8'd50, 8'd6, lat);
        checks++;
        if (lat !== 9 || quotient !== 8'd8 || remainder !== 8'd2) begin
            errors++;
            $display("FAIL reset_mid_50_6: lat=%0d q=%0d r=%0d want 9 8 2", lat, quotient, remainder);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(8'd77, 8'd10, lat);
        run_op(8'd250, 8'd16, lat);
        checks++;
        if (quotient !== 8'd15 || remainder !== 8'd10) begin
            errors++;
            $display("FAIL b2b_250_16: q=%0d r=%0d want 15 10", quotient, remainder);
        end
    endtask

`ifdef DIVIDER_SIGNED_EN
    task automatic test_signed();
        int lat;
        run_op(8'hF9, 8'h02, lat);
        checks++;
        if (quotient !== 8'hFD || remainder !== 8'hFF) begin
            errors++;
            $display("FAIL signed_m7_2: q=%0h r=%0h want fd ff", quotient, remainder);
        end
        run_op(8'h80, 8'hFF, lat);
        checks++;
        if (quotient !== 8'h80 || remainder !== 8'h00) begin
            errors++;
            $display("FAIL signed_min_m1: q=%0h r=%0h want 80 0", quotient, remainder);
        end
        run_op(8'h07, 8'hFE, lat);
        checks++;
        if (quotient !== 8'hFD || remainder !== 8'h01) begin
            errors++;
            $display("FAIL signed_7_m2: q=%0h r=%0h want fd 1", quotient, remainder);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_boundaries();
        test_ignore_inflight();
        test_back_to_back();
`ifdef DIVIDER_SIGNED_EN
        test_signed();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
- Sequential unsigned integer divider; the inverse operation to the combinational array multiplier in the Integer arithmetic library.
- Uses the restoring shift/subtract algorithm and resolves one quotient bit per clock.
- Handshake: single-cycle start pulse in, single-cycle result-valid pulse out.
- Intended as the multicycle divide unit beside the multipliers in the Integer datapath.

Parameters:
- DATA_WIDTH, 8, bits in dividend, divisor, quotient and remainder. Must be a power of 2, minimum 4.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- dividend_i  input  DATA_WIDTH  dividend; sampled only on acceptance.
- divisor_i  input  DATA_WIDTH  divisor; sampled only on acceptance.
- data_valid_i  input  1  start request.
- quotient_o  output  DATA_WIDTH  registered quotient.
- remainder_o  output  DATA_WIDTH  registered remainder.
- data_valid_o  output  1  one-cycle pulse when results update.
- divide_by_zero_o  output  1  qualifies the current result as divide-by-zero; held with the result.
- idle_o  output  1  high when a start request will be accepted.

Behaviour:
- Reset (asynchronous, any state, including mid-division):
  - state goes to IDLE.
  - quotient_o, remainder_o, counter and all internal registers go to 0.
  - data_valid_o and divide_by_zero_o go to 0; idle_o goes to 1.
- FSM states: IDLE, DIVIDE, DONE. idle_o = (state == IDLE).
- IDLE:
  - data_valid_i=1 and divisor_i != 0: latch the operands, clear the partial remainder, counter = DATA_WIDTH-1, go to DIVIDE.
  - data_valid_i=1 and divisor_i == 0: load quotient = all ones and remainder = dividend_i, set divide_by_zero, go to DONE.
- DIVIDE, each cycle:
  - Shift {partial remainder, dividend} left by 1; trial = partial remainder - divisor, computed DATA_WIDTH+1 bits wide.
  - If trial is non-negative: keep trial and shift in quotient bit 1. Otherwise restore and shift in 0.
  - Counter decrements. When counter == 0, the step completes and the FSM goes to DONE.
- DONE:
  - quotient_o and remainder_o update and data_valid_o=1 for exactly this cycle.
  - Unconditionally return to IDLE.
  - data_valid_i is ignored here, as it is in DIVIDE.
- Latency:
  - Normal operation: data_valid_o rises DATA_WIDTH+1 cycles after the acceptance edge.
  - Divide-by-zero: 1 cycle.
  - Throughput: one operation per DATA_WIDTH+2 cycles.
- Results:
  - quotient_o, remainder_o and divide_by_zero_o hold their values until the next DONE.
  - divide_by_zero_o clears on the next non-zero-divisor completion.
- Input changes after acceptance do not affect the operation in flight.
- Arithmetic invariant (normal case): dividend = quotient*divisor + remainder, with remainder < divisor.
- Dividend < divisor yields q=0, r=dividend; no special path is needed.

Optional Feature:
- Macro: DIVIDER_SIGNED_EN.
- Defined:
  - Operands and results are two's-complement.
  - Operand magnitudes are taken on acceptance and the unsigned core runs on them.
  - The quotient is negated if the operand signs differ (truncation toward zero); the remainder takes the sign of the dividend.
  - Fix-up is applied in DONE with no extra latency.
  - MIN / -1 gives quotient MIN, remainder 0.
  - Divide-by-zero gives quotient -1, remainder = dividend.
- Undefined: purely unsigned as above; no sign logic is synthesised.

Decomposition:
- Package divider_pkg:
  - typedef enum logic [1:0] divider_fsm_t {IDLE, DIVIDE, DONE}.
  - Function returning the counter width, $clog2(DATA_WIDTH).
- Sub-module restoring_divider_step (combinational, DATA_WIDTH parameter):
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: next partial remainder and quotient bit.

Test Plan (DATA_WIDTH=8, unsigned build unless stated):
- 100 / 7 accepted in IDLE -> 9 cycles later data_valid_o=1 for one cycle, quotient_o=14, remainder_o=2, divide_by_zero_o=0.
- 5 / 0 -> next cycle data_valid_o=1, quotient_o=0xFF, remainder_o=5, divide_by_zero_o=1; a following 9/3 completion gives q=3, r=0 and clears divide_by_zero_o.
- 255 / 1 and 3 / 200 -> q=255, r=0, then q=0, r=3.
- Second data_valid_i pulse during DIVIDE plus operand changes after acceptance -> ignored; first result unchanged; idle_o=0 until after DONE.
- rst_n_i low in cycle 4 of DIVIDE -> immediately all outputs 0, idle_o=1, no data_valid_o pulse; a new 50/6 then yields q=8, r=2.
- DIVIDER_SIGNED_EN build: -7/2 -> q=-3, r=-1; -128/-1 -> q=-128, r=0; 7/-2 -> q=-3, r=1.
